// File: rtl/uart_move_pkg.sv
// Shared types and constants for the UART chess-move parser.
package uart_move_pkg;

    // Parser position within a "<file><rank><file><rank><term>" command.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FR    = 3'd1,
        S_TF    = 3'd2,
        S_TR    = 3'd3,
        S_EOL   = 3'd4,
        S_PEND  = 3'd5,
        S_FLUSH = 3'd6
    } state_e;

    // Role of a received byte inside a move command.
    typedef enum logic [2:0] {
        CLS_FILE  = 3'd0,
        CLS_RANK  = 3'd1,
        CLS_TERM  = 3'd2,
        CLS_BKSP  = 3'd3,
        CLS_SPACE = 3'd4,
        CLS_OTHER = 3'd5
    } char_cls_e;

    localparam logic [1:0] ERR_BAD_CHAR = 2'd0;
    localparam logic [1:0] ERR_BAD_LEN  = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd2;
    localparam logic [1:0] ERR_OVERRUN  = 2'd3;

    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_LF   = 8'h0A;
    localparam logic [7:0] ASCII_BS   = 8'h08;
    localparam logic [7:0] ASCII_DEL  = 8'h7F;
    localparam logic [7:0] ASCII_SP   = 8'h20;
    localparam logic [7:0] ASCII_LC_A = 8'h61;
    localparam logic [7:0] ASCII_LC_H = 8'h68;
    localparam logic [7:0] ASCII_UC_A = 8'h41;
    localparam logic [7:0] ASCII_UC_H = 8'h48;
    localparam logic [7:0] ASCII_1    = 8'h31;
    localparam logic [7:0] ASCII_8    = 8'h38;

    // True while a command is partially typed (the states the timeout watches).
    function automatic logic in_command(input state_e s);
        return (s == S_FR) || (s == S_TF) || (s == S_TR) || (s == S_EOL);
    endfunction

endpackage

// File: rtl/move_char_classify.sv
// Combinational byte classifier: maps a received byte to its class and 3-bit coordinate value.
module move_char_classify
    import uart_move_pkg::*;
(
    input  logic [7:0] i_data,
    output char_cls_e  o_cls,
    output logic [2:0] o_val
);

    // Classify the byte; files are case-folded, value is the offset from 'a'/'A'/'1'.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        o_cls = CLS_OTHER;
        o_val = 3'd0;
        if (i_data >= ASCII_LC_A && i_data <= ASCII_LC_H) begin
            o_cls = CLS_FILE;
            o_val = 3'(i_data - ASCII_LC_A);
        end else if (i_data >= ASCII_UC_A && i_data <= ASCII_UC_H) begin
            o_cls = CLS_FILE;
            o_val = 3'(i_data - ASCII_UC_A);
        end else if (i_data >= ASCII_1 && i_data <= ASCII_8) begin
            o_cls = CLS_RANK;
            o_val = 3'(i_data - ASCII_1);
        end else if (i_data == ASCII_CR || i_data == ASCII_LF) begin
            o_cls = CLS_TERM;
        end else if (i_data == ASCII_BS || i_data == ASCII_DEL) begin
            o_cls = CLS_BKSP;
        end else if (i_data == ASCII_SP) begin
            o_cls = CLS_SPACE;
        end
    end

endmodule

// File: rtl/uart_move_parser.sv
// Parses typed chess moves from the UART byte stream and holds each move until acknowledged.
module uart_move_parser
    import uart_move_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 100_000_000,
    parameter int unsigned CNT_W          = 27
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] i_rx_data,
    input  logic       i_rx_valid,
    input  logic       i_move_ack,
    output logic       o_move_valid,
    output logic [2:0] o_from_file,
    output logic [2:0] o_from_rank,
    output logic [2:0] o_to_file,
    output logic [2:0] o_to_rank,
    output logic       o_err,
    output logic [1:0] o_err_code,
    output logic       o_busy
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e           state_q, state_d;
    state_e           eff_state;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    // Working coordinates of the command being typed.
    logic [2:0]       wrk_ff_q, wrk_ff_d, wrk_fr_q, wrk_fr_d;
    logic [2:0]       wrk_tf_q, wrk_tf_d, wrk_tr_q, wrk_tr_d;
    // Presented coordinates, only updated by a complete, valid command.
    logic [2:0]       out_ff_q, out_ff_d, out_fr_q, out_fr_d;
    logic [2:0]       out_tf_q, out_tf_d, out_tr_q, out_tr_d;
    logic             err_q, err_d;
    logic [1:0]       err_code_q, err_code_d;

    char_cls_e        cls;
    logic [2:0]       val;
    logic             byte_act;
    logic             timeout;

    move_char_classify u_classify (
        .i_data (i_rx_data),
        .o_cls  (cls),
        .o_val  (val)
    );

    assign byte_act = i_rx_valid && (cls != CLS_SPACE);
    assign timeout  = in_command(state_q) && (cnt_q == CNT_LAST);

    // Next-state, coordinate capture, error and timeout-counter logic.
    always_comb begin
        state_d    = state_q;
        eff_state  = state_q;
        cnt_d      = cnt_q;
        wrk_ff_d   = wrk_ff_q;
        wrk_fr_d   = wrk_fr_q;
        wrk_tf_d   = wrk_tf_q;
        wrk_tr_d   = wrk_tr_q;
        out_ff_d   = out_ff_q;
        out_fr_d   = out_fr_q;
        out_tf_d   = out_tf_q;
        out_tr_d   = out_tr_q;
        err_d      = 1'b0;
        err_code_d = err_code_q;

        // A stalled partial command is dropped; a byte on this cycle is seen from IDLE.
        if (timeout) begin
            err_d      = 1'b1;
            err_code_d = ERR_TIMEOUT;
            state_d    = S_IDLE;
            eff_state  = S_IDLE;
        end

        // Acknowledge releases the held move; a same-cycle byte is seen from IDLE.
        if (state_q == S_PEND && i_move_ack) begin
            state_d   = S_IDLE;
            eff_state = S_IDLE;
        end

        if (byte_act) begin
            case (eff_state)
                S_IDLE: begin
                    case (cls)
                        CLS_FILE: begin
                            wrk_ff_d = val;
                            state_d  = S_FR;
                        end
                        CLS_TERM, CLS_BKSP: ;
                        default: begin
                            err_d      = 1'b1;
                            err_code_d = ERR_BAD_CHAR;
                            state_d    = S_FLUSH;
                        end
                    endcase
                end
                S_FR: begin
                    case (cls)
                        CLS_RANK: begin
                            wrk_fr_d = val;
                            state_d  = S_TF;
                        end
                        CLS_BKSP: state_d = S_IDLE;
                        CLS_TERM: begin
                            err_d      = 1'b1;
                            err_code_d = ERR_BAD_LEN;
                            state_d    = S_FLUSH;
                        end
                        default: begin
                            err_d      = 1'b1;
                            err_code_d = ERR_BAD_CHAR;
                            state_d    = S_FLUSH;
                        end
                    endcase
                end
                S_TF: begin
                    case (cls)
                        CLS_FILE: begin
                            wrk_tf_d = val;
                            state_d  = S_TR;
                        end
                        CLS_BKSP: state_d = S_FR;
                        CLS_TERM: begin
                            err_d      = 1'b1;
                            err_code_d = ERR_BAD_LEN;
                            state_d    = S_FLUSH;
                        end
                        default: begin
                            err_d      = 1'b1;
                            err_code_d = ERR_BAD_CHAR;
                            state_d    = S_FLUSH;
                        end
                    endcase
                end
                S_TR: begin
                    case (cls)
                        CLS_RANK: begin
                            wrk_tr_d = val;
                            state_d  = S_EOL;
                        end
                        CLS_BKSP: state_d = S_TF;
                        CLS_TERM: begin
                            err_d      = 1'b1;
                            err_code_d = ERR_BAD_LEN;
                            state_d    = S_FLUSH;
                        end
                        default: begin
                            err_d      = 1'b1;
                            err_code_d = ERR_BAD_CHAR;
                            state_d    = S_FLUSH;
                        end
                    endcase
                end
                S_EOL: begin
                    case (cls)
                        CLS_TERM: begin
                            if ({wrk_ff_q, wrk_fr_q} == {wrk_tf_q, wrk_tr_q}) begin
                                // Null move: terminator already consumed, so no flush.
                                err_d      = 1'b1;
                                err_code_d = ERR_BAD_LEN;
                                state_d    = S_IDLE;
                            end else begin
                                out_ff_d = wrk_ff_q;
                                out_fr_d = wrk_fr_q;
                                out_tf_d = wrk_tf_q;
                                out_tr_d = wrk_tr_q;
                                state_d  = S_PEND;
                            end
                        end
                        CLS_BKSP: state_d = S_TR;
                        CLS_FILE, CLS_RANK: begin
                            err_d      = 1'b1;
                            err_code_d = ERR_BAD_LEN;
                            state_d    = S_FLUSH;
                        end
                        default: begin
                            err_d      = 1'b1;
                            err_code_d = ERR_BAD_CHAR;
                            state_d    = S_FLUSH;
                        end
                    endcase
                end
                S_PEND: begin
                    err_d      = 1'b1;
                    err_code_d = ERR_OVERRUN;
                end
                S_FLUSH: begin
                    if (cls == CLS_TERM) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end

        // Inter-byte idle counter runs only while a command is partially typed.
        if (timeout || byte_act || !in_command(state_q)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State, counter, coordinate and error registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            wrk_ff_q   <= 3'd0;
            wrk_fr_q   <= 3'd0;
            wrk_tf_q   <= 3'd0;
            wrk_tr_q   <= 3'd0;
            out_ff_q   <= 3'd0;
            out_fr_q   <= 3'd0;
            out_tf_q   <= 3'd0;
            out_tr_q   <= 3'd0;
            err_q      <= 1'b0;
            err_code_q <= 2'd0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wrk_ff_q   <= wrk_ff_d;
            wrk_fr_q   <= wrk_fr_d;
            wrk_tf_q   <= wrk_tf_d;
            wrk_tr_q   <= wrk_tr_d;
            out_ff_q   <= out_ff_d;
            out_fr_q   <= out_fr_d;
            out_tf_q   <= out_tf_d;
            out_tr_q   <= out_tr_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end

    assign o_move_valid = (state_q == S_PEND);
    assign o_from_file  = out_ff_q;
    assign o_from_rank  = out_fr_q;
    assign o_to_file    = out_tf_q;
    assign o_to_rank    = out_tr_q;
    assign o_err        = err_q;
    assign o_err_code   = err_code_q;
    assign o_busy       = (state_q != S_IDLE) && (state_q != S_PEND);

endmodule

// File: tb/tb_uart_move_parser.sv
// Self-checking bench for uart_move_parser: directed scenarios plus random byte streams
// compared cycle by cycle against a line-buffer reference model.
module tb_uart_move_parser;

    localparam int unsigned T = 40;

    logic       clk;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       move_ack;
    logic       move_valid;
    logic [2:0] from_file, from_rank, to_file, to_rank;
    logic       err;
    logic [1:0] err_code;
    logic       busy;

    int checks;
    int errors;

    uart_move_parser #(
        .TIMEOUT_CYCLES (T),
        .CNT_W          (27)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_rx_data    (rx_data),
        .i_rx_valid   (rx_valid),
        .i_move_ack   (move_ack),
        .o_move_valid (move_valid),
        .o_from_file  (from_file),
        .o_from_rank  (from_rank),
        .o_to_file    (to_file),
        .o_to_rank    (to_rank),
        .o_err        (err),
        .o_err_code   (err_code),
        .o_busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model: typed-line buffer ----------------
    int unsigned blen;          // characters of the current command accepted so far
    logic [2:0]  bval [4];
    bit          flushing;
    bit          pending;
    int unsigned age;           // idle cycles since last accepted byte of a partial command
    logic        exp_valid, exp_err, exp_busy;
    logic [1:0]  exp_code;
    logic [2:0]  exp_ff, exp_fr, exp_tf, exp_tr;

    function automatic bit is_file(input logic [7:0] b);
        return (b >= "a" && b <= "h") || (b >= "A" && b <= "H");
    endfunction
    function automatic bit is_rank(input logic [7:0] b);
        return b >= "1" && b <= "8";
    endfunction
    function automatic bit is_term(input logic [7:0] b);
        return b == 8'h0D || b == 8'h0A;
    endfunction
    function automatic bit is_bksp(input logic [7:0] b);
        return b == 8'h08 || b == 8'h7F;
    endfunction
    function automatic logic [2:0] coord(input logic [7:0] b);
        int v;
        if (b >= "a" && b <= "h")      v = b - "a";
        else if (b >= "A" && b <= "H") v = b - "A";
        else                           v = b - "1";
        return 3'(v);
    endfunction

    task automatic model_reset();
        blen = 0; flushing = 0; pending = 0; age = 0;
        exp_valid = 0; exp_err = 0; exp_busy = 0; exp_code = 0;
        exp_ff = 0; exp_fr = 0; exp_tf = 0; exp_tr = 0;
    endtask

    task automatic raise(input logic [1:0] c);
        exp_err  = 1'b1;
        exp_code = c;
    endtask

    task automatic model_step(input logic v, input logic [7:0] d, input logic ack);
        bit partial0, tmo, act;
        partial0 = (blen > 0) && !flushing && !pending;
        exp_err  = 1'b0;
        tmo      = partial0 && (age == T - 1);
        if (tmo) begin
            raise(2'd2);
            blen = 0;
        end
        if (pending && ack) begin
            pending   = 0;
            exp_valid = 0;
        end
        act = v && (d != 8'h20);
        if (act) begin
            if (pending) raise(2'd3);
            else if (flushing) begin
                if (is_term(d)) flushing = 0;
            end else if (is_bksp(d)) begin
                if (blen > 0) blen--;
            end else if (is_term(d)) begin
                if (blen == 0) begin
                    // empty line
                end else if (blen < 4) begin
                    raise(2'd1); flushing = 1; blen = 0;
                end else if (bval[0] == bval[2] && bval[1] == bval[3]) begin
                    raise(2'd1); blen = 0;
                end else begin
                    exp_ff = bval[0]; exp_fr = bval[1]; exp_tf = bval[2]; exp_tr = bval[3];
                    pending = 1; exp_valid = 1; blen = 0;
                end
            end else if (blen == 4) begin
                raise((is_file(d) || is_rank(d)) ? 2'd1 : 2'd0);
                flushing = 1; blen = 0;
            end else if ((blen % 2 == 0) ? is_file(d) : is_rank(d)) begin
                bval[blen] = coord(d);
                blen++;
            end else begin
                raise(2'd0); flushing = 1; blen = 0;
            end
        end
        age      = (tmo || act || !partial0) ? 0 : age + 1;
        exp_busy = flushing || (blen > 0);
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ":busy"},  32'(busy),       32'(exp_busy));
        check({tag, ":valid"}, 32'(move_valid), 32'(exp_valid));
        check({tag, ":err"},   32'(err),        32'(exp_err));
        check({tag, ":code"},  32'(err_code),   32'(exp_code));
        check({tag, ":coords"}, {20'd0, from_file, from_rank, to_file, to_rank},
              {20'd0, exp_ff, exp_fr, exp_tf, exp_tr});
    endtask

    // One clock of stimulus: drive at the falling edge, compare at the next falling edge.
    task automatic drive(input logic v, input logic [7:0] d, input logic ack, input string tag);
        rx_valid = v;
        rx_data  = d;
        move_ack = ack;
        model_step(v, d, ack);
        @(negedge clk);
        compare_all(tag);
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        move_ack = 1'b0;
    endtask

    task automatic send(input string s);
        for (int i = 0; i < s.len(); i++) drive(1'b1, s[i], 1'b0, s);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 1'b0, "idle");
    endtask

    task automatic check_move(input string tag, input int ff, input int fr, input int tf, input int tr);
        check({tag, ":valid"}, 32'(move_valid), 32'd1);
        check({tag, ":from"}, {26'd0, from_file, from_rank}, 32'((ff << 3) | fr));
        check({tag, ":to"},   {26'd0, to_file, to_rank},     32'((tf << 3) | tr));
    endtask

    function automatic logic [7:0] rand_byte();
        int unsigned r;
        r = $urandom_range(99);
        if (r < 28)      return 8'h61 + 8'($urandom_range(7));
        else if (r < 33) return 8'h41 + 8'($urandom_range(7));
        else if (r < 63) return 8'h31 + 8'($urandom_range(7));
        else if (r < 73) return ($urandom_range(1) == 0) ? 8'h0D : 8'h0A;
        else if (r < 79) return ($urandom_range(1) == 0) ? 8'h08 : 8'h7F;
        else if (r < 84) return 8'h20;
        else             return 8'($urandom_range(8'h21, 8'h2F));
    endfunction

    initial begin
        int pulses;
        logic [1:0] seen_code;
        checks = 0; errors = 0;
        rst = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; move_ack = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset:valid", 32'(move_valid), 32'd0);
        check("reset:busy",  32'(busy),       32'd0);
        check("reset:err",   32'(err),        32'd0);
        check("reset:code",  32'(err_code),   32'd0);
        check("reset:coords", {20'd0, from_file, from_rank, to_file, to_rank}, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Basic move, held until ack.
        send("e2e4\r");
        check_move("e2e4", 4, 1, 4, 3);
        idle(3);
        check_move("e2e4_hold", 4, 1, 4, 3);
        drive(1'b0, 8'h00, 1'b1, "ack");
        check("e2e4_ack:valid", 32'(move_valid), 32'd0);
        check("e2e4_ack:busy",  32'(busy),       32'd0);

        // Bad character, flush, then recovery.
        send("E7x");
        check("E7x:err",  32'(err),      32'd1);
        check("E7x:code", 32'(err_code), 32'd0);
        send("5\r");
        check("flush_quiet:err", 32'(err), 32'd0);
        send("g1f3\n");
        check_move("g1f3", 6, 0, 5, 2);
        drive(1'b0, 8'h00, 1'b1, "ack");

        // Length errors; extra CR leaves the flush of the short line.
        send("e2e\r");
        check("e2e:err",  32'(err),      32'd1);
        check("e2e:code", 32'(err_code), 32'd1);
        send("\r");
        send("e2e2\r");
        check("e2e2:err",   32'(err),        32'd1);
        check("e2e2:code",  32'(err_code),   32'd1);
        check("e2e2:valid", 32'(move_valid), 32'd0);
        check("e2e2:busy",  32'(busy),       32'd0);

        // Embedded space.
        send("b1 c3\r");
        check_move("b1c3", 1, 0, 2, 2);
        drive(1'b0, 8'h00, 1'b1, "ack");

        // Timeout after a partial command.
        send("e2");
        pulses = 0; seen_code = 2'd0;
        for (int i = 0; i < int'(T) + 10; i++) begin
            drive(1'b0, 8'h00, 1'b0, "timeout_wait");
            if (err) begin pulses++; seen_code = err_code; end
        end
        check("timeout:pulses", 32'(pulses),    32'd1);
        check("timeout:code",   32'(seen_code), 32'd2);
        check("timeout:busy",   32'(busy),      32'd0);
        send("a1a2\r");
        check_move("a1a2", 0, 0, 0, 1);

        // Overrun while a move is held.
        pulses = 0;
        drive(1'b1, "d", 1'b0, "ovr_d");
        if (err && err_code == 2'd3) pulses++;
        idle(1);
        drive(1'b1, "2", 1'b0, "ovr_2");
        if (err && err_code == 2'd3) pulses++;
        check("overrun:pulses", 32'(pulses), 32'd2);
        check_move("overrun_hold", 0, 0, 0, 1);
        drive(1'b1, "d", 1'b1, "ack_d");
        check("ack_d:valid", 32'(move_valid), 32'd0);
        check("ack_d:busy",  32'(busy),       32'd1);
        check("ack_d:err",   32'(err),        32'd0);
        send("4d5\r");
        check_move("d4d5", 3, 3, 3, 4);
        drive(1'b0, 8'h00, 1'b1, "ack");

        // Backspace editing.
        send("e2e5");
        drive(1'b1, 8'h08, 1'b0, "bksp");
        send("4\r");
        check_move("bksp_e2e4", 4, 1, 4, 3);
        drive(1'b0, 8'h00, 1'b1, "ack");

        // Asynchronous reset in the middle of a command.
        send("e2e");
        check("mid:busy", 32'(busy), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("midrst:busy",  32'(busy),       32'd0);
        check("midrst:valid", 32'(move_valid), 32'd0);
        check("midrst:err",   32'(err),        32'd0);
        check("midrst:coords", {20'd0, from_file, from_rank, to_file, to_rank}, 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        send("4\r");
        check("after_rst:valid", 32'(move_valid), 32'd0);

        // Random streams against the reference model.
        for (int i = 0; i < 1500; i++) begin
            logic       v, a;
            logic [7:0] d;
            v = ($urandom_range(99) < 65);
            d = v ? rand_byte() : 8'h00;
            a = exp_valid ? ($urandom_range(99) < 30) : ($urandom_range(99) < 5);
            drive(v, d, a, "random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
